// File: rtl/hamming74_byte_encoder.sv
// Streaming Hamming(7,4) byte encoder: byte in, two 7-bit codewords (low nibble first) out via a small FIFO.
// Optional HAMMING_ERR_INJECT_EN adds a one-shot single-bit error injector on the next pushed codeword.
module hamming74_byte_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_code,
  output logic       out_last,
  output logic       busy
`ifdef HAMMING_ERR_INJECT_EN
  ,
  input  logic       err_inj,
  input  logic [2:0] err_inj_pos
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EMIT_LO = 2'd1;
  localparam logic [1:0] EMIT_HI = 2'd2;

  function automatic logic parity3(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic [6:0] hamming_encode(input logic [3:0] d);
    return {d[3], d[2], d[1], parity3(d[1], d[2], d[3]), d[0],
            parity3(d[0], d[2], d[3]), parity3(d[0], d[1], d[3])};
  endfunction

  logic [1:0]       state_r;
  logic [7:0]       byte_r;
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic       full_s;
  logic       push_s;
  logic       pop_s;
  logic [3:0] nibble_s;
  logic [6:0] inj_mask_s;
  logic [7:0] push_word_s;

`ifdef HAMMING_ERR_INJECT_EN
  logic       arm_r;
  logic [2:0] pos_r;

  // One-shot arm: a new pulse wins over consumption so a pulse during a push arms the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_r <= 1'b0;
      pos_r <= 3'd0;
    end else if (err_inj) begin
      arm_r <= 1'b1;
      pos_r <= err_inj_pos;
    end else if (push_s) begin
      arm_r <= 1'b0;
    end
  end

  // Position 7 consumes the arm without flipping anything.
  always_comb begin
    inj_mask_s = 7'd0;
    if (arm_r && (pos_r != 3'd7)) begin
      inj_mask_s = 7'd1 << pos_r;
    end else begin
      inj_mask_s = 7'd0;
    end
  end
`else
  assign inj_mask_s = 7'd0;
`endif

  // Handshake, FIFO status and the codeword to push this cycle.
  always_comb begin
    full_s    = (count_r == FULL_COUNT);
    push_s    = ((state_r == EMIT_LO) || (state_r == EMIT_HI)) && !full_s;
    out_valid = !rst && (count_r != CNT_W'(0));
    pop_s     = out_valid && out_ready;
    in_ready  = !rst && (state_r == IDLE);
    busy      = !rst && ((state_r != IDLE) || (count_r != CNT_W'(0)));
    if (state_r == EMIT_HI) begin
      nibble_s = byte_r[7:4];
    end else begin
      nibble_s = byte_r[3:0];
    end
    push_word_s = {(state_r == EMIT_HI), hamming_encode(nibble_s) ^ inj_mask_s};
  end

  // Output word from the head entry; forced to zero whenever nothing is queued.
  always_comb begin
    if (out_valid) begin
      {out_last, out_code} = mem_r[rd_ptr_r];
    end else begin
      {out_last, out_code} = 8'd0;
    end
  end

  // Byte sequencer: capture, emit low nibble, emit high nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      byte_r  <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            byte_r  <= in_data;
            state_r <= EMIT_LO;
          end
        end
        EMIT_LO: begin
          if (!full_s) state_r <= EMIT_HI;
        end
        EMIT_HI: begin
          if (!full_s) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset because out_code is masked while empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_word_s;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth makes the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming74_byte_encoder.sv
// Self-checking bench for hamming74_byte_encoder: directed cases plus randomized traffic
// against a positional Hamming(7,4) model and an expected-codeword queue.
module tb_hamming74_byte_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_code;
  logic       out_last;
  logic       busy;
`ifdef HAMMING_ERR_INJECT_EN
  logic       err_inj;
  logic [2:0] err_inj_pos;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [6:0] inj_mask = 7'd0;
  logic       stall_v = 1'b0;
  logic [7:0] held_word = 8'd0;
  logic       rand_ready = 1'b0;

  hamming74_byte_encoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_last(out_last), .busy(busy)
`ifdef HAMMING_ERR_INJECT_EN
    , .err_inj(err_inj), .err_inj_pos(err_inj_pos)
`endif
  );

  always #5 clk = ~clk;

  // Classic positional Hamming: positions 1..7, parity at 1,2,4 covering positions with that index bit set.
  function automatic logic [6:0] model_enc(input logic [3:0] d);
    logic [7:0] w;
    logic par;
    w = 8'd0;
    w[3] = d[0]; w[5] = d[1]; w[6] = d[2]; w[7] = d[3];
    for (int p = 0; p < 3; p++) begin
      par = 1'b0;
      for (int j = 1; j < 8; j++)
        if (((j >> p) & 1) == 1 && j != (1 << p)) par = par ^ w[j];
      w[1 << p] = par;
    end
    return w[7:1];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {in_ready, out_valid, busy, out_last, out_code}, 0);
      exp_q.delete();
      stall_v = 1'b0;
    end else begin
      if (out_valid && stall_v) chk("stall_stable", {out_last, out_code}, held_word);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_codeword", {out_last, out_code}, 999);
        else chk("codeword", {out_last, out_code}, exp_q.pop_front());
      end
      stall_v   = out_valid && !out_ready;
      held_word = {out_last, out_code};
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, model_enc(in_data[3:0]) ^ inj_mask});
        exp_q.push_back({1'b1, model_enc(in_data[7:4])});
        inj_mask = 7'd0;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic send(input logic [7:0] b, output int waited);
    waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 300) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic gap_check(input string name);
    @(negedge clk); chk({name, "_ready_t1"}, in_ready, 0);
    @(negedge clk); chk({name, "_ready_t2"}, in_ready, 0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_timeout"}, (n < 1000), 1);
  endtask

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
`ifdef HAMMING_ERR_INJECT_EN
    err_inj = 1'b0; err_inj_pos = 3'd0;
`endif
    chk("pin_enc_B", model_enc(4'hB), 7'h55);
    chk("pin_enc_5", model_enc(4'h5), 7'h2D);
    chk("pin_enc_F", model_enc(4'hF), 7'h7F);
    chk("pin_enc_1", model_enc(4'h1), 7'h07);
    chk("pin_enc_0", model_enc(4'h0), 7'h00);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); chk("in_ready_after_rst", in_ready, 1);

    // Single byte: low codeword two cycles after acceptance.
    @(posedge clk); #1;
    send(8'h5B, w);
    @(negedge clk); chk("lat_t1_valid", out_valid, 0);
    @(negedge clk); chk("lat_t2_valid", out_valid, 1);
    chk("lat_t2_code", {out_last, out_code}, 8'h55);
    drain("single");

    // Back-to-back bytes: in_ready low exactly two cycles after each acceptance.
    @(posedge clk); #1;
    send(8'h00, w); gap_check("b2b0");
    send(8'hFF, w); chk("b2b_wait1", w, 0); gap_check("b2b1");
    send(8'h01, w); chk("b2b_wait2", w, 0); gap_check("b2b2");
    drain("b2b");

    // Back-pressure: FIFO fills and the third byte stalls in the low-nibble emit.
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'h5B, w);
    send(8'hFF, w);
    send(8'h01, w);
    repeat (8) @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_busy", busy, 1);
    chk("bp_head", {out_valid, out_last, out_code}, 9'h155);
    @(posedge clk); #1 out_ready = 1'b1;
    drain("bp");

    // Reset while emitting the high nibble with one entry queued.
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'h5B, w);
    @(posedge clk); #1;
    chk("mid_rst_queued", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", in_ready, 1);
    out_ready = 1'b1;
    send(8'hFF, w);
    drain("post_rst");

`ifdef HAMMING_ERR_INJECT_EN
    // Error injection: flip bit 2 of the next codeword, then a position-7 no-op arm.
    @(posedge clk); #1 err_inj = 1'b1; err_inj_pos = 3'd2; inj_mask = 7'h04;
    @(posedge clk); #1 err_inj = 1'b0;
    send(8'h5B, w);
    drain("inj2");
    @(posedge clk); #1 err_inj = 1'b1; err_inj_pos = 3'd7; inj_mask = 7'h00;
    @(posedge clk); #1 err_inj = 1'b0;
    send(8'h5B, w);
    drain("inj7");
`endif

    // Randomized traffic with random back-pressure and idle gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      send(8'($urandom), w);
    end
    rand_ready = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hamming74_byte_encoder.md
Name: hamming74_byte_encoder

Overview:
Streaming Hamming(7,4) encoder on the transmit side of the modified-Hamming link. It accepts bytes over a valid/ready handshake and splits each byte into two nibbles, low nibble first. Each nibble is encoded into a 7-bit codeword and buffered in a small output FIFO. The output side feeds the link, where the matching Hamming(7,4) decoder consumes codewords.

Parameters:
FIFO_DEPTH, 4, codeword FIFO entries; power of two, minimum 2

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data valid
in_ready  output  1  encoder can accept a byte this cycle
in_data  input  8  byte to encode; [3:0] sent first, [7:4] second
out_valid  output  1  out_code/out_last valid (FIFO not empty)
out_ready  input  1  downstream accepts codeword
out_code  output  7  codeword, bit order [6:0] = d3 d2 d1 p3 d0 p2 p1
out_last  output  1  codeword carries the high nibble of its byte
busy  output  1  FSM not IDLE or FIFO not empty

Behaviour:
- Encoding, for nibble d[3:0]:
  - p1 = d0^d1^d3; p2 = d0^d2^d3; p3 = d1^d2^d3.
  - code = {d3,d2,d1,p3,d0,p2,p1}, so bit0=p1, bit1=p2, bit2=d0, bit3=p3, bit4=d1, bit5=d2, bit6=d3.
  - Combinational from the internal byte register; no arithmetic beyond XOR.
- FSM states IDLE, EMIT_LO, EMIT_HI:
  - IDLE: in_ready=1. On in_valid&in_ready, register in_data and go to EMIT_LO.
  - EMIT_LO: if FIFO not full, push {code(byte[3:0]), last=0} and go to EMIT_HI; otherwise hold.
  - EMIT_HI: if FIFO not full, push {code(byte[7:4]), last=1} and go to IDLE; otherwise hold.
  - in_ready=0 in EMIT_LO and EMIT_HI. Peak rate is one byte per 3 cycles.
- FIFO:
  - Push and pop use pointers with a count. out_valid = (count!=0). out_code/out_last are driven from the read-pointer entry.
  - Pop on out_valid&out_ready.
  - Full is evaluated before the same-cycle pop, so no push occurs when count==FIFO_DEPTH even if a pop happens that cycle.
  - Push and pop in the same cycle (not full): count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: byte accepted in cycle T, low codeword out_valid in T+2, high codeword available in T+3 if not back-pressured.
- out_code/out_last must hold stable while out_valid=1 and out_ready=0.
- Reset, applied at any time including mid-byte:
  - FSM returns to IDLE; FIFO count and pointers are zeroed.
  - A partially emitted byte is discarded.
  - While rst=1: in_ready=0, out_valid=0, busy=0, out_last=0, out_code=0.
  - in_ready rises in the first cycle after rst deasserts.
- in_data changes while in_ready=0 are ignored.

Optional Feature:
HAMMING_ERR_INJECT_EN
- Defined: adds input ports err_inj (1) and err_inj_pos (3).
  - A 1-cycle pulse on err_inj arms a one-shot and latches err_inj_pos.
  - The next codeword pushed has bit err_inj_pos inverted (pos 0..6). Pos 7 injects nothing but still consumes the arm.
  - If a pulse coincides with a push, it arms for the following push.
  - A re-pulse while armed overwrites the position.
  - rst clears the arm.
- Undefined: the ports are absent and codewords are never altered.

Test Plan:
- Reset then byte 0x5B with out_ready=1: out_code 0x55 (last=0) then 0x2D (last=1). First out_valid 2 cycles after acceptance.
- Bytes 0x00, 0xFF, 0x01 back-to-back: codes 0x00,0x00, 0x7F,0x7F, 0x07,0x00. in_ready low 2 cycles after each acceptance.
- out_ready=0, FIFO_DEPTH=4, send 0x5B, 0xFF, 0x01:
  - FIFO fills to 4 codewords and the third byte stalls in EMIT_LO with in_ready=0.
  - Raise out_ready: 0x55,0x2D,0x7F,0x7F,0x07,0x00 emerge in order, with no drop or duplicate and out_code stable while stalled.
- Assert rst while in EMIT_HI with 1 entry queued: next cycle out_valid=0 and busy=0. After release in_ready=1, and a new byte 0xFF yields only 0x7F,0x7F.
- HAMMING_ERR_INJECT_EN defined, pulse err_inj with pos=2, then send 0x5B: codes 0x51 then 0x2D. Repeat with pos=7: 0x55, 0x2D.
- Random bytes with random out_ready: each codeword pair fed to the decoder reproduces the byte with error flag 0.
